// File: rtl/btn_edit_ctrl.sv
// Three-digit BCD editor driven by five debounced push-buttons,
// with a req/ack handshake that hands the digits to a datapath.
module btn_edit_ctrl #(
  parameter int TICK_DIV = 50_000,
  parameter int DB_COUNT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic        btn_c,
  input  logic        btn_u,
  input  logic        btn_d,
  output logic [1:0]  cursor,
  output logic [11:0] digits,
  output logic        load_req,
  input  logic        load_ack,
  output logic        busy
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_DROP
  } state_t;

  logic [TW-1:0] tcnt_q;
  logic          tick;

  assign tick = (tcnt_q == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= '0;
    end else if (tick) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_q + 1'b1;
    end
  end

  logic [4:0]    raw;
  logic [4:0]    sync1_q;
  logic [4:0]    sync2_q;
  logic [4:0]    stable_q;
  logic [4:0]    prev_q;
  logic [CW-1:0] dbc_q [5];

  assign raw = {btn_d, btn_u, btn_c, btn_r, btn_l};

  // Counts run only on ticks; any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      prev_q   <= '0;
      for (int i = 0; i < 5; i++) begin
        dbc_q[i] <= '0;
      end
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      prev_q  <= stable_q;
      if (tick) begin
        for (int i = 0; i < 5; i++) begin
          if (sync2_q[i] != stable_q[i]) begin
            if (dbc_q[i] == CW'(DB_COUNT - 1)) begin
              stable_q[i] <= sync2_q[i];
              dbc_q[i]    <= '0;
            end else begin
              dbc_q[i] <= dbc_q[i] + 1'b1;
            end
          end else begin
            dbc_q[i] <= '0;
          end
        end
      end
    end
  end

  logic [4:0] ev;
  logic       do_c;
  logic       do_l;
  logic       do_r;
  logic       do_u;
  logic       do_d;
  logic       lr_mv;

  assign ev    = stable_q & ~prev_q;
  assign do_c  = ev[2];
  assign do_l  = ~do_c & ev[0] & ~ev[1];
  assign do_r  = ~do_c & ev[1] & ~ev[0];
  assign lr_mv = do_l | do_r;
  assign do_u  = ~do_c & ~lr_mv & ev[3] & ~ev[4];
  assign do_d  = ~do_c & ~lr_mv & ev[4] & ~ev[3];

  state_t      state_q;
  logic [1:0]  cursor_q;
  logic [11:0] digits_q;
  logic        load_req_q;
  logic        busy_q;
  logic [3:0]  cur_dig;
  logic [3:0]  dig_inc;
  logic [3:0]  dig_dec;
  logic [3:0]  didx;

  assign didx    = {cursor_q, 2'b00};
  assign cur_dig = digits_q[didx +: 4];
  assign dig_inc = (cur_dig == 4'd9) ? 4'd0 : cur_dig + 4'd1;
  assign dig_dec = (cur_dig == 4'd0) ? 4'd9 : cur_dig - 4'd1;

  // Edits are accepted only in IDLE; events while busy are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cursor_q   <= 2'd0;
      digits_q   <= 12'h000;
      load_req_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          unique case (1'b1)
            do_c: begin
              state_q    <= REQ;
              load_req_q <= 1'b1;
              busy_q     <= 1'b1;
            end
            do_l: begin
              if (cursor_q != 2'd2) begin
                cursor_q <= cursor_q + 2'd1;
              end
            end
            do_r: begin
              if (cursor_q != 2'd0) begin
                cursor_q <= cursor_q - 2'd1;
              end
            end
            do_u: digits_q[didx +: 4] <= dig_inc;
            do_d: digits_q[didx +: 4] <= dig_dec;
            default: ;
          endcase
        end
        REQ: begin
          if (load_ack) begin
            state_q    <= WAIT_DROP;
            load_req_q <= 1'b0;
          end
        end
        WAIT_DROP: begin
          if (!load_ack) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          load_req_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign cursor   = cursor_q;
  assign digits   = digits_q;
  assign load_req = load_req_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_btn_edit_ctrl.sv
// Bench for btn_edit_ctrl: directed handshake/reset steps plus
// random edit presses compared against a digit/cursor model.
module tb_btn_edit_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  btn = '0;
  logic        load_ack = 1'b0;
  logic [1:0]  cursor;
  logic [11:0] digits;
  logic        load_req;
  logic        busy;

  int checks = 0;
  int fails = 0;
  int lr_cnt = 0;

  int m_cur = 0;
  int m_dig [3] = '{0, 0, 0};

  localparam int BL = 0;
  localparam int BR = 1;
  localparam int BC = 2;
  localparam int BU = 3;
  localparam int BD = 4;

  btn_edit_ctrl #(.TICK_DIV(4), .DB_COUNT(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_l    (btn[0]),
    .btn_r    (btn[1]),
    .btn_c    (btn[2]),
    .btn_u    (btn[3]),
    .btn_d    (btn[4]),
    .cursor   (cursor),
    .digits   (digits),
    .load_req (load_req),
    .load_ack (load_ack),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load_req === 1'b1) lr_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [11:0] m_digits();
    logic [11:0] v;
    v[3:0]  = 4'(m_dig[0]);
    v[7:4]  = 4'(m_dig[1]);
    v[11:8] = 4'(m_dig[2]);
    return v;
  endfunction

  task automatic model_press(input int b);
    case (b)
      BL: if (m_cur < 2) m_cur++;
      BR: if (m_cur > 0) m_cur--;
      BU: m_dig[m_cur] = (m_dig[m_cur] + 1) % 10;
      BD: m_dig[m_cur] = (m_dig[m_cur] + 9) % 10;
      default: ;
    endcase
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_cur"}, 32'(cursor), 32'(m_cur));
    chk({tag, "_dig"}, 32'(digits), 32'(m_digits()));
  endtask

  task automatic press(input int b, input int hold,
                       input int rel, input string tag);
    btn[b] = 1'b1;
    clks(hold);
    btn[b] = 1'b0;
    clks(rel);
    model_press(b);
    check_model(tag);
  endtask

  task automatic wait_lr(input string tag);
    int n;
    n = 0;
    while (load_req !== 1'b1 && n < 60) begin
      clks(1);
      n++;
    end
    chk({tag, "_lr_rise"}, 32'(load_req), 32'd1);
  endtask

  initial begin
    #1;
    chk("rst_cur", 32'(cursor), 32'd0);
    chk("rst_dig", 32'(digits), 32'h000);
    chk("rst_lr", 32'(load_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    clks(2);
    rst_n = 1'b1;
    clks(5);

    for (int i = 0; i < 3; i++) press(BU, 40, 40, "u3");
    chk("u3_no_lr", 32'(lr_cnt), 32'd0);

    for (int i = 0; i < 4; i++) press(BL, 40, 40, "l4");
    chk("l_sat", 32'(cursor), 32'd2);
    for (int i = 0; i < 5; i++) press(BR, 40, 40, "r5");
    chk("r_sat", 32'(cursor), 32'd0);

    press(BL, 40, 40, "c1");
    press(BD, 40, 40, "d_wrap");
    chk("d_wrap9", 32'(digits[7:4]), 32'd9);
    press(BU, 40, 40, "u_wrap");
    chk("u_wrap0", 32'(digits[7:4]), 32'd0);

    btn[BU] = 1'b1;
    clks(3);
    btn[BU] = 1'b0;
    clks(40);
    check_model("glitch");

    btn[BL] = 1'b1;
    btn[BR] = 1'b1;
    clks(40);
    btn[BL] = 1'b0;
    btn[BR] = 1'b0;
    clks(40);
    check_model("lr_pair");

    load_ack = 1'b1;
    clks(5);
    chk("idle_ack_busy", 32'(busy), 32'd0);
    chk("idle_ack_lr", 32'(load_req), 32'd0);
    load_ack = 1'b0;
    clks(2);

    btn[BC] = 1'b1;
    wait_lr("hs");
    chk("hs_busy_req", 32'(busy), 32'd1);
    btn[BC] = 1'b0;
    clks(4);
    chk("hs_lr_hold", 32'(load_req), 32'd1);
    load_ack = 1'b1;
    clks(1);
    chk("hs_lr_drop", 32'(load_req), 32'd0);
    chk("hs_busy_wd", 32'(busy), 32'd1);
    clks(2);
    chk("hs_busy_ack_hi", 32'(busy), 32'd1);
    load_ack = 1'b0;
    clks(1);
    chk("hs_busy_end", 32'(busy), 32'd0);
    chk("hs_lr_end", 32'(load_req), 32'd0);
    clks(40);

    btn[BC] = 1'b1;
    wait_lr("bp");
    btn[BC] = 1'b0;
    btn[BU] = 1'b1;
    clks(40);
    btn[BU] = 1'b0;
    clks(40);
    chk("bp_busy", 32'(busy), 32'd1);
    check_model("bp_hold");
    load_ack = 1'b1;
    clks(2);
    load_ack = 1'b0;
    clks(2);
    chk("bp_idle", 32'(busy), 32'd0);
    clks(40);
    check_model("bp_after");

    for (int i = 0; i < 24; i++) begin
      int b;
      case ($urandom_range(0, 3))
        0: b = BL;
        1: b = BR;
        2: b = BU;
        default: b = BD;
      endcase
      press(b, $urandom_range(30, 50),
            $urandom_range(30, 50), "rnd");
    end

    btn[BC] = 1'b1;
    wait_lr("rr");
    btn[BC] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rr_lr", 32'(load_req), 32'd0);
    chk("rr_busy", 32'(busy), 32'd0);
    chk("rr_cur", 32'(cursor), 32'd0);
    chk("rr_dig", 32'(digits), 32'h000);
    m_cur = 0;
    m_dig = '{0, 0, 0};
    clks(1);
    rst_n = 1'b1;
    clks(40);
    check_model("rr_after");
    chk("rr_after_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/btn_edit_ctrl.md
BTN_EDIT_CTRL -- requirements
Module: btn_edit_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50_000, meaning clk cycles per debounce sample tick (>=2).
REQ-002 Parameter DB_COUNT, default 4, meaning consecutive differing samples needed to accept a new button level (>=1).
REQ-003 Port clk  input  1  sole clock; all state on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port btn_l, btn_r, btn_c, btn_u, btn_d  input  1 each  raw asynchronous push-buttons, active-high.
REQ-006 Port cursor  output  2  selected digit position, 0..2.
REQ-007 Port digits  output  12  three BCD digits; digit k at bits [4k+3:4k].
REQ-008 Port load_req  output  1  request to datapath to load digits.
REQ-009 Port load_ack  input  1  datapath acknowledge, level.
REQ-010 Port busy  output  1  high whenever the handshake FSM is not IDLE.

Function
REQ-011 The tick counter SHALL count 0..TICK_DIV-1 and wrap; tick SHALL be a one-clk pulse when the count equals TICK_DIV-1.
REQ-012 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Debounce, per button, on tick only: synced level differs from stable level -> count+1; count reaching DB_COUNT -> stable takes synced level and count clears; synced equals stable -> count clears.
REQ-014 A press event SHALL be a one-clk pulse on the clk after a stable level rises 0->1; release generates no event.
REQ-015 Same-cycle event priority: C over L/R over U/D; L with R together, or U with D together, is ignored as a pair.
REQ-016 L event SHALL increment cursor, saturating at 2; R event SHALL decrement cursor, saturating at 0.
REQ-017 U event SHALL increment the digit at cursor, 9 wrapping to 0; D event SHALL decrement it, 0 wrapping to 9; other digits unchanged.
REQ-018 Digit values SHALL never leave 0..9; cursor SHALL never reach 3.
REQ-019 FSM states IDLE, REQ, WAIT_DROP; IDLE + C event -> REQ; REQ + load_ack=1 -> WAIT_DROP; WAIT_DROP + load_ack=0 -> IDLE.
REQ-020 load_req SHALL be registered and high exactly while in REQ; it SHALL assert the clk after the C event and deassert the clk after load_ack is sampled high.
REQ-021 busy SHALL be registered and equal (state != IDLE).
REQ-022 While busy, all press events SHALL be discarded, not queued; cursor and digits SHALL hold.
REQ-023 load_ack in IDLE SHALL be ignored; load_ack held high across WAIT_DROP SHALL keep the FSM in WAIT_DROP.
REQ-024 Debounce and synchronizer SHALL keep running while busy, so a button held through busy produces no event on return to IDLE.

Reset
REQ-025 rst_n low SHALL immediately clear tick counter, synchronizers, stable levels, debounce counts, cursor=0, digits=12'h000, load_req=0, busy=0, state=IDLE.
REQ-026 Reset asserted mid-handshake SHALL drop load_req without waiting for load_ack.
REQ-027 Buttons held high at reset release SHALL produce an event only after debounce completes (stable resets to 0).

Verification (TICK_DIV=4, DB_COUNT=2)
REQ-028 Press btn_u 3 times, each held 40 clk -> digits=12'h003, cursor=0, load_req never asserted.
REQ-029 Press btn_l 4 times, then btn_r 5 times -> cursor reaches 2 and holds, then 0 and holds.
REQ-030 cursor=1, digit1=0, press btn_d -> digits[7:4]=9; press btn_u -> 0; digits 0 and 2 unchanged.
REQ-031 Press btn_c; ack after 5 clk, drop ack after 3 clk -> load_req high from clk after event to clk after ack; busy high until clk after ack drops; btn_u press during busy leaves digits unchanged.
REQ-032 btn_u glitch high for 3 clk (< one full debounce) -> no event; btn_l and btn_r pressed together -> cursor unchanged.
REQ-033 In REQ, pulse rst_n low 1 clk -> load_req=0, busy=0, cursor=0, digits=12'h000 asynchronously.
